// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan decoder: active-low segment
// patterns, special codes and the decoded code type.
package ssd_pkg;

   typedef logic [3:0] ssd_code_t;

   localparam ssd_code_t CODE_BLANK   = 4'hF;
   localparam ssd_code_t CODE_INVALID = 4'hE;

   // {g,f,e,d,c,b,a}, 0 = segment lit
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Bus between a multiplexed seven-segment driver (master) and the scan
// decoder (slave): raw drive lines in, committed digits and status out.
interface ssd_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg_in;
   logic [NUM_DIGITS-1:0]   an_in;
   logic                    sample_en;
   logic [4*NUM_DIGITS-1:0] digits_out;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    frame_valid;
   logic                    ghost_err;

   modport master (
      output seg_in, an_in, sample_en,
      input  digits_out, digit_err, frame_valid, ghost_err
   );

   modport slave (
      input  seg_in, an_in, sample_en,
      output digits_out, digit_err, frame_valid, ghost_err
   );
endinterface

// File: rtl/ssd_pattern_decode.sv
// Combinational map from an active-low seven-segment pattern to its code;
// anything that is not a digit or blank decodes as CODE_INVALID.
module ssd_pattern_decode
   import ssd_pkg::*;
(
   input  logic [6:0] seg,
   output ssd_code_t  code
);

   always_comb begin
      code = CODE_INVALID;
      case (seg)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_BLANK: code = CODE_BLANK;
         default:   code = CODE_INVALID;
      endcase
   end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Samples a multiplexed common-anode display drive, decodes the active digit
// and commits it once the same code has been seen STABLE_CNT times in a row.
module ssd_scan_decoder
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int STABLE_CNT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   ssd_scan_decoder_if.slave   bus
);

   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0] STABLE_V = CW'(STABLE_CNT);

   logic [6:0]              seg_p1_q, seg_p1_d;
   logic [NUM_DIGITS-1:0]   an_p1_q, an_p1_d;
   logic                    vld_p1_q, vld_p1_d;

   ssd_code_t               cand_q [NUM_DIGITS];
   ssd_code_t               cand_d [NUM_DIGITS];
   logic [CW-1:0]           cnt_q  [NUM_DIGITS];
   logic [CW-1:0]           cnt_d  [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   upd_q, upd_d;

   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   err_q, err_d;
   logic                    frame_q, frame_d;
   logic                    ghost_q, ghost_d;

   ssd_code_t               code;
   logic [NUM_DIGITS-1:0]   act;
   logic [NUM_DIGITS-1:0]   commit;
   logic                    onehot;

   ssd_pattern_decode u_dec (
      .seg  (seg_p1_q),
      .code (code)
   );

   // Stage 1: capture the drive lines on a sample strobe
   always_comb begin
      seg_p1_d = seg_p1_q;
      an_p1_d  = an_p1_q;
      vld_p1_d = bus.sample_en;
      if (bus.sample_en) begin
         seg_p1_d = bus.seg_in;
         an_p1_d  = bus.an_in;
      end
   end

   // Stage 2: one-hot check, per-digit stability tracking, commit and frame
   always_comb begin
      act     = ~an_p1_q;
      onehot  = (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);
      commit  = '0;
      digits_d = digits_q;
      err_d    = err_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         cand_d[i] = cand_q[i];
         cnt_d[i]  = cnt_q[i];
         if (vld_p1_q && onehot && act[i]) begin
            if (code == cand_q[i]) begin
               if (cnt_q[i] != STABLE_V) cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
               cand_d[i] = code;
               cnt_d[i]  = CW'(1);
            end
            commit[i] = (cnt_d[i] == STABLE_V) && (cnt_q[i] != STABLE_V);
            if (commit[i]) begin
               digits_d[4*i +: 4] = code;
               err_d[i]           = (code == CODE_INVALID);
            end
         end
      end
      ghost_d = vld_p1_q && !onehot;
      // A commit on the completing edge closes the current frame, not the next
      if ((upd_q | commit) == '1) begin
         frame_d = 1'b1;
         upd_d   = '0;
      end else begin
         frame_d = 1'b0;
         upd_d   = upd_q | commit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_p1_q <= '1;
         an_p1_q  <= '1;
         vld_p1_q <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            cand_q[i] <= CODE_BLANK;
            cnt_q[i]  <= '0;
         end
         upd_q    <= '0;
         digits_q <= '1;
         err_q    <= '0;
         frame_q  <= 1'b0;
         ghost_q  <= 1'b0;
      end else begin
         seg_p1_q <= seg_p1_d;
         an_p1_q  <= an_p1_d;
         vld_p1_q <= vld_p1_d;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            cand_q[i] <= cand_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         upd_q    <= upd_d;
         digits_q <= digits_d;
         err_q    <= err_d;
         frame_q  <= frame_d;
         ghost_q  <= ghost_d;
      end
   end

   assign bus.digits_out  = digits_q;
   assign bus.digit_err   = err_q;
   assign bus.frame_valid = frame_q;
   assign bus.ghost_err   = ghost_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed scenarios then randomized scanning,
// compared every cycle against a run-length reference model of the display.
module tb_ssd_scan_decoder;

   localparam int N = 4;
   localparam int S = 3;
   localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
      7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000};
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] JUNK  = 7'b0101010;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ssd_scan_decoder_if #(.NUM_DIGITS(N)) bus ();
   ssd_scan_decoder_if #(.NUM_DIGITS(N)) bus1 ();

   ssd_scan_decoder #(.NUM_DIGITS(N), .STABLE_CNT(S)) dut (
      .clk (clk), .rst_n (rst_n), .bus (bus));
   ssd_scan_decoder #(.NUM_DIGITS(N), .STABLE_CNT(1)) dut1 (
      .clk (clk), .rst_n (rst_n), .bus (bus1));

   int checks = 0;
   int failures = 0;
   int frames = 0;

   // Reference model: unbounded run length of identical codes per digit
   int          run  [N];
   logic [3:0]  last [N];
   logic [15:0] exp_digits;
   logic [3:0]  exp_err;
   logic [3:0]  pend;
   logic        exp_frame, exp_ghost;
   logic        m_vld;
   logic [6:0]  m_seg;
   logic [3:0]  m_an;

   function automatic logic [3:0] ref_dec(input logic [6:0] s);
      for (int k = 0; k < 10; k++) if (s == PAT[k]) return 4'(k);
      if (s == BLANK) return 4'hF;
      return 4'hE;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         run[k]  = 0;
         last[k] = 4'hF;
      end
      exp_digits = 16'hFFFF;
      exp_err    = '0;
      pend       = '0;
      exp_frame  = 1'b0;
      exp_ghost  = 1'b0;
      m_vld      = 1'b0;
      m_seg      = '1;
      m_an       = '1;
   endtask

   task automatic model_edge();
      int n;
      int d;
      logic [3:0] c;
      exp_frame = 1'b0;
      exp_ghost = 1'b0;
      if (m_vld) begin
         n = 0;
         d = 0;
         for (int k = 0; k < N; k++) if (!m_an[k]) begin n++; d = k; end
         if (n != 1) exp_ghost = 1'b1;
         else begin
            c = ref_dec(m_seg);
            if (c == last[d]) run[d]++;
            else begin
               last[d] = c;
               run[d]  = 1;
            end
            if (run[d] == S) begin
               exp_digits[4*d +: 4] = c;
               exp_err[d] = (c == 4'hE);
               pend[d] = 1'b1;
               if (pend == 4'hF) begin
                  exp_frame = 1'b1;
                  pend = '0;
               end
            end
         end
      end
      m_vld = bus.sample_en;
      m_seg = bus.seg_in;
      m_an  = bus.an_in;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("digits_out", bus.digits_out, exp_digits);
      chk("digit_err", 16'(bus.digit_err), 16'(exp_err));
      chk("frame_valid", 16'(bus.frame_valid), 16'(exp_frame));
      chk("ghost_err", 16'(bus.ghost_err), 16'(exp_ghost));
      if (bus.frame_valid === 1'b1) frames++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic samp(input logic [6:0] s, input logic [3:0] a);
      bus.seg_in    = s;
      bus.an_in     = a;
      bus.sample_en = 1'b1;
      tick();
      bus.sample_en = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.sample_en = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   logic [6:0] cur_seg;
   int         cur_dig;
   int         r;

   initial begin
      rst_n = 1'b0;
      bus.seg_in = '1;  bus.an_in = '1;  bus.sample_en = 1'b0;
      bus1.seg_in = '1; bus1.an_in = '1; bus1.sample_en = 1'b0;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Digit 0: two samples of "3" are not enough, the third commits
      samp(PAT[3], 4'b1110);
      samp(PAT[3], 4'b1110);
      idle(3);
      chk("two_samples_no_commit", 16'(bus.digits_out[3:0]), 16'hF);
      samp(PAT[3], 4'b1110);
      samp(PAT[3], 4'b1110);
      samp(PAT[3], 4'b1110);
      idle(2);
      chk("digit0_three", 16'(bus.digits_out[3:0]), 16'h3);

      // Digit 2: 5,5,7,7,7 commits only 7
      samp(PAT[5], 4'b1011);
      samp(PAT[5], 4'b1011);
      samp(PAT[7], 4'b1011);
      samp(PAT[7], 4'b1011);
      samp(PAT[7], 4'b1011);
      idle(2);
      chk("digit2_seven", 16'(bus.digits_out[11:8]), 16'h7);

      // Async reset in the middle of a count
      samp(PAT[9], 4'b0111);
      bus.seg_in = PAT[9]; bus.an_in = 4'b0111; bus.sample_en = 1'b1;
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      bus.sample_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Scan "1234" for three rounds, then a fourth identical round
      frames = 0;
      for (int rnd = 0; rnd < 3; rnd++)
         for (int d = 0; d < N; d++) samp(PAT[d+1], ~(4'b0001 << d));
      idle(3);
      chk("frame_4321", bus.digits_out, 16'h4321);
      chk("frame_once", 16'(frames), 16'd1);
      for (int d = 0; d < N; d++) samp(PAT[d+1], ~(4'b0001 << d));
      idle(3);
      chk("frame_no_repeat", 16'(frames), 16'd1);

      // Ghost samples and blank
      samp(PAT[8], 4'b0000);
      samp(PAT[8], 4'b1100);
      samp(PAT[8], 4'b1111);
      idle(2);
      chk("ghost_no_change", bus.digits_out, 16'h4321);
      samp(BLANK, 4'b0111);
      samp(BLANK, 4'b0111);
      samp(BLANK, 4'b0111);
      idle(2);
      chk("blank_digit3", 16'(bus.digits_out[15:12]), 16'hF);
      chk("blank_no_err", 16'(bus.digit_err[3]), 16'h0);

      // Invalid pattern on digit 1
      samp(JUNK, 4'b1101);
      samp(JUNK, 4'b1101);
      samp(JUNK, 4'b1101);
      idle(2);
      chk("invalid_code", 16'(bus.digits_out[7:4]), 16'hE);
      chk("invalid_err", 16'(bus.digit_err), 16'b0010);

      // STABLE_CNT=1 instance commits on the first sample
      bus1.seg_in = JUNK; bus1.an_in = 4'b1101; bus1.sample_en = 1'b1;
      tick();
      bus1.sample_en = 1'b0;
      chk("s1_latency", 16'(bus1.digits_out[7:4]), 16'hF);
      tick();
      chk("s1_commit", 16'(bus1.digits_out[7:4]), 16'hE);
      chk("s1_err", 16'(bus1.digit_err), 16'b0010);

      // Randomized scanning with sticky digit and pattern choices
      cur_seg = PAT[2];
      cur_dig = 0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(3) == 0) begin
            r = $urandom_range(3);
            cur_seg = (r == 0) ? PAT[2] : (r == 1) ? PAT[8] : (r == 2) ? BLANK : JUNK;
         end
         if ($urandom_range(3) == 0) cur_dig = $urandom_range(N-1);
         bus.seg_in    = cur_seg;
         bus.an_in     = ($urandom_range(9) == 0) ? 4'($urandom_range(15))
                                                  : ~(4'b0001 << cur_dig);
         bus.sample_en = ($urandom_range(4) != 0);
         tick();
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
